// File: rtl/gen_sensores_pkg.sv
// Shared types and constants for the two-sensor car-passage waveform generator:
// FSM states, {a,b} phase codes, direction constants and the phase-code lookup.
package gen_sensores_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        PH4  = 3'd4
    } state_t;

    localparam logic [1:0] CODE_A    = 2'b10;
    localparam logic [1:0] CODE_AB   = 2'b11;
    localparam logic [1:0] CODE_B    = 2'b01;
    localparam logic [1:0] CODE_NONE = 2'b00;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    // A retreat repeats the first sensor in PH3 instead of the opposite one.
    function automatic logic [1:0] phase_code(input state_t st, input logic dir,
                                              input logic retreat);
        logic [1:0] first_code;
        logic [1:0] third_code;
        first_code = (dir == DIR_EXIT) ? CODE_B : CODE_A;
        third_code = retreat ? first_code : ((dir == DIR_EXIT) ? CODE_A : CODE_B);
        case (st)
            PH1:     return first_code;
            PH2:     return CODE_AB;
            PH3:     return third_code;
            default: return CODE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/generador_secuencia_sensores_temporizador_fase.sv
// Phase timer: loadable down-counter that holds at zero and flags terminal count.
module temporizador_fase #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/generador_secuencia_sensores.sv
// Encodes entry/exit (full or retreat) commands into timed {a,b} sensor waveforms.
// Define SENSOR_ACTIVE_LOW_EN to drive a/b inverted (idle/reset level 1).
//
// Handshake: a command is taken on a posedge where cmd_valid && cmd_ready; cmd_ready
// is high only while idle, so cmd_valid during a sequence is ignored, not queued.
module generador_secuencia_sensores
    import gen_sensores_pkg::*;
#(
    parameter int PHASE_CYCLES = 240000,
    parameter int CNT_W        = $clog2(PHASE_CYCLES)
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   cmd_valid,
    input  logic   cmd_dir,
    input  logic   cmd_retreat,
    output logic   cmd_ready,
    output logic   a,
    output logic   b,
    output logic   busy,
    output logic   done,
    output state_t dbg_state
);

`ifdef SENSOR_ACTIVE_LOW_EN
    localparam logic [1:0] OUT_INV = 2'b11;
`else
    localparam logic [1:0] OUT_INV = 2'b00;
`endif

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    state_t           next_phase;
    logic             dir_q;
    logic             ret_q;
    logic [1:0]       ab_q;
    logic             accept;
    logic             timer_load;
    logic [CNT_W-1:0] timer_cnt;
    logic             timer_tc;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        next_phase = IDLE;
        timer_load = 1'b0;
        case (state)
            IDLE: timer_load = accept;
            PH1: begin next_phase = PH2; timer_load = timer_tc; end
            PH2: begin next_phase = PH3; timer_load = timer_tc; end
            PH3: begin next_phase = PH4; timer_load = timer_tc; end
            default: next_phase = IDLE;
        endcase
    end

    temporizador_fase #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (busy),
        .load_val (LOAD_VAL),
        .count    (timer_cnt),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            ret_q     <= 1'b0;
            ab_q      <= CODE_NONE ^ OUT_INV;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= PH1;
                        dir_q     <= cmd_dir;
                        ret_q     <= cmd_retreat;
                        ab_q      <= phase_code(PH1, cmd_dir, cmd_retreat) ^ OUT_INV;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                PH1, PH2, PH3: begin
                    if (timer_tc) begin
                        state <= next_phase;
                        ab_q  <= phase_code(next_phase, dir_q, ret_q) ^ OUT_INV;
                    end
                end
                PH4: begin
                    // done is registered one cycle early so it lands on the last PH4 cycle.
                    if (timer_tc) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        done <= (timer_cnt == ONE);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign dbg_state = state;

endmodule

// File: tb/tb_generador_secuencia_sensores.sv
// Directed bench for generador_secuencia_sensores with PHASE_CYCLES=4.
module tb_generador_secuencia_sensores;
    import gen_sensores_pkg::*;

`ifdef SENSOR_ACTIVE_LOW_EN
    localparam logic [1:0] INV = 2'b11;
`else
    localparam logic [1:0] INV = 2'b00;
`endif

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   cmd_valid = 1'b0;
    logic   cmd_dir = 1'b0;
    logic   cmd_retreat = 1'b0;
    logic   cmd_ready;
    logic   a;
    logic   b;
    logic   busy;
    logic   done;
    state_t dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    generador_secuencia_sensores #(.PHASE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_dir     (cmd_dir),
        .cmd_retreat (cmd_retreat),
        .cmd_ready   (cmd_ready),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       dir;
        logic       retreat;
        logic [7:0] codes;
    } vec_t;

    vec_t  vecs[4];
    string names[4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with cmd_ready expected high; accept happens on the next posedge.
    task automatic issue(input logic dir, input logic ret);
        cmd_valid   = 1'b1;
        cmd_dir     = dir;
        cmd_retreat = ret;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Checks cycles 1..n after the accept edge; optionally pulses cmd_dir at cycle pulse_at.
    task automatic expect_seq(input logic [7:0] codes, input string tag, input int n,
                              input int pulse_at);
        logic [1:0] exp_ab;
        int ph;
        for (int cyc = 1; cyc <= n; cyc++) begin
            @(negedge clk);
            ph     = (cyc - 1) / 4;
            exp_ab = codes[7-2*ph -: 2] ^ INV;
            check($sformatf("%s ab c%0d", tag, cyc), {6'b0, a, b}, {6'b0, exp_ab});
            check($sformatf("%s ctl c%0d", tag, cyc), {5'b0, busy, cmd_ready, done},
                  {5'b0, 1'b1, 1'b0, (cyc == 16)});
            if (cyc == pulse_at) cmd_dir = ~cmd_dir;
            if (cyc == pulse_at + 1) cmd_dir = ~cmd_dir;
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, " ab"}, {6'b0, a, b}, {6'b0, INV});
        check({tag, " ctl"}, {5'b0, busy, cmd_ready, done}, 8'b0000_0010);
    endtask

    initial begin
        vecs[0] = '{dir: 1'b0, retreat: 1'b0, codes: 8'b10_11_01_00}; names[0] = "entry_full";
        vecs[1] = '{dir: 1'b1, retreat: 1'b0, codes: 8'b01_11_10_00}; names[1] = "exit_full";
        vecs[2] = '{dir: 1'b0, retreat: 1'b1, codes: 8'b10_11_10_00}; names[2] = "entry_retreat";
        vecs[3] = '{dir: 1'b1, retreat: 1'b1, codes: 8'b01_11_01_00}; names[3] = "exit_retreat";

        // Reset held three cycles, then released.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold ab", {6'b0, a, b}, {6'b0, INV});
        rst = 1'b0;
        expect_idle("after_reset");
        check("after_reset state", {5'b0, dbg_state}, {5'b0, IDLE});

        // Table-driven: every command type, issued back to back.
        for (int i = 0; i < 4; i++) begin
            issue(vecs[i].dir, vecs[i].retreat);
            expect_seq(vecs[i].codes, names[i], 16, 0);
            expect_idle({names[i], " end"});
        end

        // cmd_valid held across two sequences; a mid-sequence dir pulse must be ignored.
        cmd_valid   = 1'b1;
        cmd_dir     = DIR_ENTRY;
        cmd_retreat = 1'b0;
        @(posedge clk);
        expect_seq(vecs[0].codes, "held1", 16, 6);
        expect_idle("held gap");
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        expect_seq(vecs[0].codes, "held2", 16, 0);
        expect_idle("held end");

        // Reset during PH2 aborts, then a fresh entry plays in full.
        issue(DIR_ENTRY, 1'b0);
        expect_seq(vecs[0].codes, "abort", 5, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        expect_idle("abort reset");
        check("abort state", {5'b0, dbg_state}, {5'b0, IDLE});
        issue(DIR_ENTRY, 1'b0);
        expect_seq(vecs[0].codes, "after_abort", 16, 0);
        expect_idle("after_abort end");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/generador_secuencia_sensores.md
Name: generador_secuencia_sensores

Overview:
Stimulus-side counterpart of the parking-lot control FSM. It encodes a car-passage command (entry or exit, full or retreat) into the timed two-sensor waveform on a and b that the FSM decodes into S/R pulses. It serves as the bench and demo driver that replaces BTN1/BTN4 for automated counter exercise and on-board self-test. It sits upstream of the antirebote instances, or feeds the FSM directly when PHASE_CYCLES is short.

Parameters:
PHASE_CYCLES, 240000, clock cycles each sensor phase is held (20 ms at 12 MHz; must exceed debounce time when feeding antirebote); minimum 2.
CNT_W, $clog2(PHASE_CYCLES), width of the phase timer.

Ports:
clk  input  1  system clock, single clock domain.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command request.
cmd_dir  input  1  0 = entry (a first), 1 = exit (b first).
cmd_retreat  input  1  1 = car enters sensor zone then backs out (no net passage).
cmd_ready  output  1  high when idle and able to accept a command.
a  output  1  emulated sensor pair 'a', registered.
b  output  1  emulated sensor pair 'b', registered.
busy  output  1  sequence in progress.
done  output  1  one-cycle pulse in the last cycle of a sequence.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, a=0, b=0, busy=0, done=0, cmd_ready=1, timer=0, latched command cleared. Reset mid-sequence aborts immediately; the partial waveform is not completed.
- Handshake: a command is accepted on a posedge with cmd_valid && cmd_ready. cmd_dir and cmd_retreat are latched on that edge. cmd_valid while busy is ignored, with no queueing.
- FSM states: IDLE, PH1, PH2, PH3, PH4. Each PHx lasts exactly PHASE_CYCLES cycles. The timer loads PHASE_CYCLES-1 on entry to each phase and advances on terminal count.
- Phase codes {a,b}:
  - entry full: PH1=10, PH2=11, PH3=01, PH4=00.
  - exit full: 01, 11, 10, 00.
  - entry retreat: 10, 11, 10, 00.
  - exit retreat: 01, 11, 01, 00.
- Latency: accept at edge k. PH1 levels are visible from cycle k+1. busy=1 and cmd_ready=0 for exactly 4*PHASE_CYCLES cycles. done=1 in the final PH4 cycle. cmd_ready=1 in the next cycle, so back-to-back commands leave no dead cycle beyond that.
- PH4 (both clear) guarantees the downstream FSM returns to rest before the next command.
- a/b change only on phase boundaries and never glitch. They are registered outputs, with no combinational path from inputs.
- The timer never wraps: the terminal count advances the phase, and PH4 terminal count returns to IDLE.

Optional Feature:
SENSOR_ACTIVE_LOW_EN. When defined, a and b are driven inverted (idle/reset level 1), matching raw BTN pin polarity so the block can replace BTN1/BTN4 ahead of the ~BTN inversion. When undefined, a and b are active-high, idle 0. All other outputs are unaffected.

Decomposition:
- Package gen_sensores_pkg:
  - state encoding localparams (IDLE, PH1..PH4).
  - 2-bit phase codes (CODE_A=10, CODE_AB=11, CODE_B=01, CODE_NONE=00).
  - DIR_ENTRY/DIR_EXIT constants.
- One sub-module: temporizador_fase, a loadable down-counter with load, enable and terminal-count output, sized by CNT_W.

Test Plan (PHASE_CYCLES=4):
- Reset: hold rst 3 cycles -> a=0, b=0, busy=0, done=0, cmd_ready=1 on the cycle after release.
- Entry full, cmd_dir=0, cmd_retreat=0 -> {a,b} = 10 x4, 11 x4, 01 x4, 00 x4; done on cycle 16 after accept; cmd_ready on cycle 17. Downstream FSM emits exactly one S pulse.
- Exit full, cmd_dir=1 -> 01 x4, 11 x4, 10 x4, 00 x4; exactly one R pulse downstream.
- Entry retreat -> 10 x4, 11 x4, 10 x4, 00 x4; no S or R downstream. Exit retreat -> 01, 11, 01, 00.
- cmd_valid held high throughout two sequences -> second accepted only at the cycle cmd_ready=1; opposing cmd_dir pulsed mid-sequence is ignored.
- rst asserted during PH2 (11) -> next cycle a=b=0, busy=0, cmd_ready=1; a following entry command produces the full 16-cycle waveform. Repeat with SENSOR_ACTIVE_LOW_EN: all a/b levels inverted, reset level 11.
